// File: rtl/mux_n_stream.sv
// N-input registered stream multiplexer: external or round-robin channel select
// feeding a one-entry output register with valid/ready on every port.
module mux_n_stream #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned SEL_W   = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [NUM_IN-1:0]       in_valid_i,
  output logic [NUM_IN-1:0]       in_ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_idx_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic [SEL_W-1:0] out_idx_d,  out_idx_q;
  logic             out_valid_d, out_valid_q;
  logic [SEL_W-1:0] ptr_d, ptr_q;

  assign load = !out_valid_q || out_ready_i;

  always_comb begin
    int unsigned cand;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    cand       = 0;
    if (RR_MODE != 0) begin
      // Search starts at ptr and wraps explicitly so non-power-of-2 NUM_IN works.
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cand = 32'(ptr_q) + i;
        if (cand >= NUM_IN) cand = cand - NUM_IN;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
          if (!grant_vld && (k == cand) && in_valid_i[k]) begin
            grant_vld  = 1'b1;
            grant_idx  = SEL_W'(k);
            grant_data = in_data_i[k*WIDTH +: WIDTH];
          end
        end
      end
    end else begin
      // Out-of-range selects match no channel and therefore never grant.
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if ((sel_i == SEL_W'(k)) && in_valid_i[k]) begin
          grant_vld  = 1'b1;
          grant_idx  = SEL_W'(k);
          grant_data = in_data_i[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      in_ready_o[k] = rst_ni && load && grant_vld && (grant_idx == SEL_W'(k));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_vld) begin
        out_data_d  = grant_data;
        out_idx_d   = grant_idx;
        out_valid_d = 1'b1;
        ptr_d       = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: doc/mux_n_stream.md
# mux_n_stream

Parametrised N-input, registered stream multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the fixed 4:1 combinational data-path select: width and input count are parameters, selection is either external or round-robin arbitrated, and the output is held in a one-entry pipeline register. It sits between multiple producers, such as writeback sources or load/store response paths, and a single consumer stage.

## Interface
- WIDTH, 32: data bits per channel.
- NUM_IN, 4: number of input channels, 2..16.
- RR_MODE, 0: 0 selects by `sel_i`; 1 selects by internal round-robin arbitration and ignores `sel_i`.
- SEL_W, $clog2(NUM_IN): width of the select and index fields (derived).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- in_data_i  in  NUM_IN*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid_i  in  NUM_IN  per-channel valid.
- in_ready_o  out  NUM_IN  per-channel ready (combinational).
- sel_i  in  SEL_W  channel select; used only when RR_MODE=0.
- out_data_o  out  WIDTH  registered output data.
- out_idx_o  out  SEL_W  index of the channel that produced `out_data_o`.
- out_valid_o  out  1  registered output valid.
- out_ready_i  in  1  consumer ready.

## Operation
- A transfer on any port occurs when valid and ready are both 1 on the same rising edge.
- Output register load enable: `load = !out_valid_o || out_ready_i`.
- Grant g (one-hot or none) is computed combinationally each cycle:
  - RR_MODE=0: g = channel `sel_i` if `sel_i < NUM_IN` and `in_valid_i[sel_i]` is 1. Otherwise there is no grant, and an out-of-range `sel_i` never grants.
  - RR_MODE=1: g = the first channel with valid=1, searching from `ptr` upward and wrapping modulo NUM_IN. `ptr` is a SEL_W-bit register.
- `in_ready_o[k] = load && (g == k)`. At most one bit of `in_ready_o` is set in any cycle.
- On a clock edge where `load` is 1:
  - With a grant: `out_data_o`, `out_idx_o` and `out_valid_o` capture the granted channel's data, its index, and 1.
  - Without a grant: `out_valid_o` goes to 0. `out_data_o` and `out_idx_o` hold their values.
- On a clock edge where `load` is 0: all output registers hold. While `out_valid_o`=1 and `out_ready_i`=0, data, index and valid are stable.
- Round-robin pointer:
  - Updates only on an accepted input transfer to channel k.
  - The new value is k+1, wrapping to 0 after NUM_IN-1. For non-power-of-2 NUM_IN, the wrap is explicit at NUM_IN-1.
  - No grant, or a stalled output, leaves `ptr` unchanged.
- Changing `sel_i` while the output is stalled has no effect on the held output. It affects only the next grant.

## Timing
- Latency: input accepted at edge N, so the data is on `out_data_o` with `out_valid_o`=1 after edge N.
- Throughput: one transfer per cycle when the consumer holds `out_ready_i`=1.
- The output-side pop and the input-side push happen on the same edge: a simultaneous drain and refill gives no bubble.
- The path from `out_ready_i` to `in_ready_o` is combinational. There is no combinational path from any input to `out_*`.
- Reset values, when `rst_ni`=0 at an edge:
  - `out_valid_o`=0, `out_data_o`=0, `out_idx_o`=0, `ptr`=0.
  - `in_ready_o` is forced to all-0 while `rst_ni`=0.
- Reset mid-transfer: held output data is discarded and no handshake completes on that edge. After reset, the first RR grant searches from channel 0.

## Test plan
- RR_MODE=0, WIDTH=32, NUM_IN=4, all channels valid with data 0xA0..0xA3, `out_ready_i`=1, `sel_i` = 2, 0, 3, 1 on consecutive cycles.
  - Required: one cycle later, `out_data_o` = 0xA2, 0xA0, 0xA3, 0xA1 with `out_idx_o` = 2, 0, 3, 1.
  - Required: exactly one `in_ready_o` bit is set per cycle.
- RR_MODE=1, all four channels valid continuously, `out_ready_i`=1.
  - Required: `out_idx_o` sequence 0, 1, 2, 3, 0, 1 with no idle cycles.
  - Then only channels 1 and 3 valid: grants alternate 1, 3, 1, 3.
- Backpressure: output holds 0x55 from channel 0 while `out_ready_i`=0 for 3 cycles and channel 1 stays valid.
  - Required: `out_data_o` stays 0x55 and `in_ready_o` = 0000 throughout.
  - Required: when ready rises, channel 1 is accepted that same edge and appears next cycle with no bubble.
- RR_MODE=0, NUM_IN=3, `sel_i`=3 while all channels are valid.
  - Required: `in_ready_o` = 000 and `out_valid_o` drops to 0 after the edge.
- Synchronous reset asserted while `out_valid_o`=1 and `ptr`=2.
  - Required: next edge gives `out_valid_o`=0, `out_data_o`=0, `out_idx_o`=0.
  - Required: the first RR grant after reset goes to channel 0 when all channels are valid.
  - Required: deasserting `rst_ni` between edges changes nothing until the next edge.
